md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage instruction is mult/multu/div/divu; one-cycle pulse.
REQ-006 md_op  input  3  operation: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 rs_val  input  32  forwarded rs operand, E stage.
REQ-008 rt_val  input  32  forwarded rt operand, E stage.
REQ-009 we_hl  input  1  E-stage mthi/mtlo write strobe.
REQ-010 md_use_D  input  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 busy  output  1  operation in progress.
REQ-012 stall_md  output  1  freeze F/D register and bubble D/E.
REQ-013 md_out  output  32  HI for MFHI, LO for MFLO, else 0.

Function
REQ-014 Two states, IDLE and BUSY; IDLE->BUSY on start, BUSY->IDLE when counter reaches 1.
REQ-015 On start in IDLE: latch operands, load counter with MULT_CYC or DIV_CYC per md_op.
REQ-016 busy SHALL be 1 for exactly N cycles after the start cycle (cycles t+1..t+N), registered.
REQ-017 HI/LO SHALL update on the clock edge ending cycle t+N; new values visible from t+N+1.
REQ-018 stall_md SHALL equal md_use_D & (start | busy), combinational.
REQ-019 MULT: {HI,LO} = signed 32x32 -> 64 product; MULTU: unsigned.
REQ-020 DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend; DIVU unsigned.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divisor zero: HI and LO SHALL remain unchanged; busy timing unaffected.
REQ-023 MTHI/MTLO with we_hl in IDLE SHALL write rs_val to HI/LO at next edge, no busy.
REQ-024 start or we_hl while BUSY SHALL be ignored (prevented upstream by stall_md).
REQ-025 start and we_hl together SHALL be treated as start only.
REQ-026 md_out SHALL read current HI/LO registers combinationally, no internal forwarding.
REQ-027 Counter width SHALL be ceil(log2(max(MULT_CYC,DIV_CYC)+1)) bits; no wrap.

Reset
REQ-028 reset SHALL force HI=0, LO=0, busy=0, counter=0, state IDLE, next edge.
REQ-029 reset during BUSY SHALL abandon the operation; HI/LO not updated with its result.
REQ-030 reset SHALL dominate start and we_hl in the same cycle.

Structure
REQ-031 md_op encodings and default MULT_CYC/DIV_CYC SHALL live in shared package md_pkg.
REQ-032 Arithmetic SHALL sit in one combinational sub-module md_arith (op, a, b -> hi, lo).
REQ-033 FSM, counter, HI/LO registers and stall logic SHALL be in md_unit.

Verification
REQ-034 MULT rs=0xFFFFFFFE, rt=3 -> busy cycles 1-5, HI=0xFFFFFFFF, LO=0xFFFFFFFA at cycle 6.
REQ-035 DIVU rs=100, rt=7 -> busy 10 cycles, LO=14, HI=2; md_use_D=1 throughout gives stall_md=1 from start to cycle 10.
REQ-036 DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV rs=0x80000000, rt=-1 -> LO=0x80000000, HI=0.
REQ-037 MTHI rs=0x12345678 in IDLE, then MFHI -> md_out=0x12345678 next cycle, busy stays 0.
REQ-038 DIV by zero with HI=5, LO=9 -> HI=5, LO=9 after 10 busy cycles.
REQ-039 reset at busy cycle 3 of MULT -> busy=0, HI=LO=0 next cycle; new start accepted immediately.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies, FSM state type and a small decode helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Purely combinational multiply/divide datapath producing HI/LO results
// for the latched operation and operands.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  // Result selection; the signed overflow case is pinned explicitly.
  always_comb begin
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'h0000_0000, a} * {32'h0000_0000, b};
    sq    = 32'sh0000_0000;
    sr    = 32'sh0000_0000;
    hi    = 32'h0000_0000;
    lo    = 32'h0000_0000;
    case (op)
      MD_MULT:  {hi, lo} = sprod;
      MD_MULTU: {hi, lo} = uprod;
      MD_DIV: begin
        if (b == 32'h0000_0000) begin
          hi = 32'h0000_0000;
          lo = 32'h0000_0000;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          hi = 32'h0000_0000;
          lo = 32'h8000_0000;
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          hi = sr;
          lo = sq;
        end
      end
      MD_DIVU: begin
        if (b == 32'h0000_0000) begin
          hi = 32'h0000_0000;
          lo = 32'h0000_0000;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      default: begin
        hi = 32'h0000_0000;
        lo = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy sequencing
// and the pipeline stall request for dependent D-stage instructions.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        we_hl,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  md_arith u_arith (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .hi (res_hi),
    .lo (res_lo)
  );

  // Next-state: accept start/mthi/mtlo only in IDLE, commit result on last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          busy_d  = 1'b1;
          op_d    = md_op;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (we_hl) begin
          case (md_op)
            MD_MTHI: hi_d = rs_val;
            MD_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          // A zero divisor leaves HI/LO untouched but keeps the normal latency.
          if (is_div_op(op_q) && (b_q == 32'h0000_0000)) begin
            hi_d = hi_q;
            lo_d = lo_q;
          end else begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0000_0000;
      lo_q    <= 32'h0000_0000;
      op_q    <= 3'd0;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // HI/LO read port, no forwarding of in-flight results.
  always_comb begin
    case (md_op)
      MD_MFHI: md_out = hi_q;
      MD_MFLO: md_out = lo_q;
      default: md_out = 32'h0000_0000;
    endcase
  end

  assign busy     = busy_q;
  assign stall_md = md_use_D & (start | busy_q);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of arithmetic vectors checked via a
// result scoreboard, plus hand sequences for reset, MTHI/MTLO and busy corners.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        we_hl = 1'b0;
  logic        md_use_D = 1'b0;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .we_hl    (we_hl),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .md_out   (md_out)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hl_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } vec_t;

  hl_t         sb_q[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    md_op = MD_MFHI;
    #1;
    h = md_out;
    md_op = MD_MFLO;
    #1;
    l = md_out;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] eh, input logic [31:0] el,
                        input logic we, input string name);
    logic [31:0] h, l;
    hl_t exp;
    int n;
    md_use_D = 1'b1;
    start = 1'b1;
    we_hl = we;
    md_op = op;
    rs_val = a;
    rt_val = b;
    #1;
    chk({name, " stall_start"}, {31'd0, stall_md}, 32'd1);
    sb_q.push_back('{hi: eh, lo: el});
    tick;
    start = 1'b0;
    we_hl = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      read_hl(h, l);
      chk({name, " hi_hold"}, h, model_hi);
      chk({name, " lo_hold"}, l, model_lo);
      md_op = MD_MULT;
      #1;
      chk({name, " stall_busy"}, {31'd0, stall_md}, 32'd1);
      tick;
    end
    chk({name, " busy_cycles"}, n, cyc);
    exp = sb_q.pop_front();
    read_hl(h, l);
    chk({name, " hi"}, h, exp.hi);
    chk({name, " lo"}, l, exp.lo);
    model_hi = exp.hi;
    model_lo = exp.lo;
    md_op = MD_MULT;
    #1;
    chk({name, " stall_idle"}, {31'd0, stall_md}, 32'd0);
    chk({name, " md_out_other"}, md_out, 32'h0);
  endtask

  initial begin
    logic [31:0] h, l;
    int n;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  "mult_neg2x3"};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5,  "multu_big"};
    vecs[2] = '{MD_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0023, 5,  "mult_negneg"};
    vecs[3] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  "multu_max"};
    vecs[4] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5,  "mult_min"};
    vecs[5] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10, "divu_100_7"};
    vecs[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_m7_2"};
    vecs[7] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div_ovf"};
    vecs[8] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_7_m2"};

    // reset state
    md_use_D = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst stall", {31'd0, stall_md}, 32'd0);
    read_hl(h, l);
    chk("rst hi", h, 32'h0);
    chk("rst lo", l, 32'h0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].name);

    // MTHI / MTLO in idle
    md_use_D = 1'b0;
    md_op = MD_MTHI; rs_val = 32'h1234_5678; we_hl = 1'b1;
    tick;
    we_hl = 1'b0;
    md_op = MD_MFHI;
    #1;
    chk("mthi md_out", md_out, 32'h1234_5678);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    md_op = MD_MFLO;
    #1;
    chk("mthi lo_keep", md_out, model_lo);
    model_hi = 32'h1234_5678;
    md_op = MD_MTLO; rs_val = 32'd9; we_hl = 1'b1;
    tick;
    md_op = MD_MTHI; rs_val = 32'd5;
    tick;
    we_hl = 1'b0;
    model_hi = 32'd5;
    model_lo = 32'd9;
    read_hl(h, l);
    chk("mt hi5", h, 32'd5);
    chk("mt lo9", l, 32'd9);

    // divide by zero keeps HI/LO with full latency
    run_op(MD_DIV, 32'd77, 32'd0, 10, 32'd5, 32'd9, 1'b0, "div_zero");
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, "divu_max");

    // start together with we_hl acts as start only
    run_op(MD_MULTU, 32'h0000_0010, 32'h0000_0010, 5, 32'h0, 32'h0000_0100, 1'b1, "start_we");

    // start and MTHI while busy are ignored
    md_use_D = 1'b1;
    start = 1'b1; md_op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7;
    tick;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      if (n == 2) begin
        start = 1'b1; md_op = MD_DIVU; rs_val = 32'd1; rt_val = 32'd1;
      end else if (n == 3) begin
        start = 1'b0; we_hl = 1'b1; md_op = MD_MTHI; rs_val = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; we_hl = 1'b0; md_op = MD_MULT;
      end
      tick;
    end
    start = 1'b0;
    we_hl = 1'b0;
    chk("ignore busy_cycles", n, 32'd5);
    read_hl(h, l);
    chk("ignore hi", h, 32'h0);
    chk("ignore lo", l, 32'd42);
    model_hi = 32'h0;
    model_lo = 32'd42;

    // reset at busy cycle 3 abandons the operation
    start = 1'b1; md_op = MD_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    tick;
    start = 1'b0; md_op = MD_MULT;
    tick;
    tick;
    chk("rstbusy pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rstbusy busy", {31'd0, busy}, 32'd0);
    read_hl(h, l);
    chk("rstbusy hi", h, 32'h0);
    chk("rstbusy lo", l, 32'h0);
    model_hi = 32'h0;
    model_lo = 32'h0;
    run_op(MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, "after_rst");

    // reset dominates start and we_hl
    reset = 1'b1; start = 1'b1; md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd3;
    tick;
    start = 1'b0;
    md_op = MD_MTHI; rs_val = 32'hAAAA_5555; we_hl = 1'b1;
    tick;
    reset = 1'b0; we_hl = 1'b0;
    #1;
    chk("rstdom busy", {31'd0, busy}, 32'd0);
    read_hl(h, l);
    chk("rstdom hi", h, 32'h0);
    chk("rstdom lo", l, 32'h0);
    tick;
    chk("rstdom busy2", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
